// File: rtl/dir_cmd_queue_if.sv
// Button-event bus between the top-level synchronisers and the heading queue.
// The master side drives the buttons and tick strobes. The slave side returns the registered heading state.
interface dir_cmd_queue_if #(
    parameter int CNT_W = 3
);
    logic             game_en;
    logic             pause;
    logic             isUp;
    logic             isDown;
    logic             isLeft;
    logic             isRight;
    logic [1:0]       heading;
    logic             heading_chg;
    logic [CNT_W-1:0] q_count;
    logic             drop_evt;

    modport master (
        output game_en, pause, isUp, isDown, isLeft, isRight,
        input  heading, heading_chg, q_count, drop_evt
    );

    modport slave (
        input  game_en, pause, isUp, isDown, isLeft, isRight,
        output heading, heading_chg, q_count, drop_evt
    );
endinterface

// File: rtl/dir_cmd_queue.sv
// Turns stretched button levels into a queued, tick-paced snake heading.
// Direction encoding: 0=up 1=down 2=left 3=right.
module dcq_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic lvl,
    output logic rise
);
    logic hist;

    // History resets high so that a button held through reset does not count as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) hist <= 1'b1;
        else        hist <= lvl;
    end

    assign rise = lvl & ~hist;
endmodule

module dir_cmd_queue #(
    parameter int         DEPTH    = 2,
    parameter int         CNT_W    = 3,
    parameter logic [1:0] INIT_DIR = 2'd3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dir_cmd_queue_if.slave        bus
);
    logic [3:0]       btn;
    logic [3:0]       rise;
    logic [1:0]       ev_dir;
    logic             ev_vld;
    logic             ev_multi;
    logic [1:0]       ref_dir;
    logic [1:0]       newest_ptr;
    logic             deq;
    logic             full;
    logic             rej_dir;
    logic             acc;
    logic             drop_nxt;

    logic [1:0]       q_mem [0:3];
    logic [1:0]       wr_ptr;
    logic [1:0]       rd_ptr;
    logic [CNT_W-1:0] q_cnt;
    logic [1:0]       heading_q;
    logic             chg_q;
    logic             drop_q;

    // The bit index of btn is the direction code.
    assign btn = {bus.isRight, bus.isLeft, bus.isDown, bus.isUp};

    dcq_edge u_edge [3:0] (
        .clk   (clk),
        .rst_n (rst_n),
        .lvl   (btn),
        .rise  (rise)
    );

    // The lowest direction code wins when several buttons rise together.
    always_comb begin
        ev_dir = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (rise[i]) ev_dir = 2'(i);
    end

    assign ev_vld   = |rise;
    assign ev_multi = (rise & (rise - 4'd1)) != 4'd0;

    assign newest_ptr = (wr_ptr == 2'd0) ? 2'(DEPTH - 1) : wr_ptr - 2'd1;
    assign ref_dir    = (q_cnt != '0) ? q_mem[newest_ptr] : heading_q;

    assign deq      = bus.game_en && !bus.pause && (q_cnt != '0);
    assign full     = (q_cnt - CNT_W'(deq)) == CNT_W'(DEPTH);
    assign rej_dir  = (ev_dir == ref_dir) || (ev_dir == (ref_dir ^ 2'b01));
    assign acc      = ev_vld && !rej_dir && !full;
    assign drop_nxt = ev_multi || (ev_vld && !acc);

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) q_mem[i] <= 2'd0;
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            q_cnt     <= '0;
            heading_q <= INIT_DIR;
            chg_q     <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            if (acc) begin
                q_mem[wr_ptr] <= ev_dir;
                wr_ptr        <= ptr_inc(wr_ptr);
            end
            if (deq) begin
                heading_q <= q_mem[rd_ptr];
                rd_ptr    <= ptr_inc(rd_ptr);
            end
            case ({acc, deq})
                2'b10:   q_cnt <= q_cnt + CNT_W'(1);
                2'b01:   q_cnt <= q_cnt - CNT_W'(1);
                default: q_cnt <= q_cnt;
            endcase
            chg_q  <= deq;
            drop_q <= drop_nxt;
        end
    end

    assign bus.heading     = heading_q;
    assign bus.heading_chg = chg_q;
    assign bus.q_count     = q_cnt;
    assign bus.drop_evt    = drop_q;
endmodule

// File: tb/tb_dir_cmd_queue.sv
// Bench for dir_cmd_queue. Per-cycle expectations come from a vector table.
// Dequeued headings are checked against a queue of accepted turns.
module tb_dir_cmd_queue;
    logic clk = 1'b0;
    logic rst_n;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    dir_cmd_queue_if #(.CNT_W(3)) bus();

    dir_cmd_queue #(.DEPTH(2), .CNT_W(3), .INIT_DIR(2'd3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef struct {
        logic [3:0] btn;   // {up, down, left, right}
        logic       ge;
        logic       ps;
        logic [1:0] h;
        int         cnt;
        logic       chg;
        logic       drop;
        logic       push;
        logic [1:0] pd;
    } vec_t;

    vec_t       vt [38];
    logic [1:0] exp_q [$];

    function automatic vec_t mk(input logic [3:0] b, input logic ge, input logic ps,
                                input logic [1:0] h, input int cnt, input logic chg,
                                input logic drop, input logic push, input logic [1:0] pd);
        vec_t r;
        r.btn = b; r.ge = ge; r.ps = ps; r.h = h; r.cnt = cnt;
        r.chg = chg; r.drop = drop; r.push = push; r.pd = pd;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Every heading_chg must deliver the oldest accepted turn.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.heading_chg === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("sb_unexpected_chg", 1, 0);
            end else begin
                chk("sb_heading", int'(bus.heading), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        //             btn     ge ps h  cnt chg drp psh pd
        vt[0]  = mk(4'b1000, 0, 0, 3, 0, 0, 0, 0, 0);   // up held through reset
        vt[1]  = mk(4'b1000, 0, 0, 3, 0, 0, 0, 0, 0);
        vt[2]  = mk(4'b0000, 0, 0, 3, 0, 0, 0, 0, 0);
        vt[3]  = mk(4'b0010, 0, 0, 3, 0, 0, 1, 0, 0);   // left reverses right
        vt[4]  = mk(4'b0000, 0, 0, 3, 0, 0, 0, 0, 0);
        vt[5]  = mk(4'b0001, 0, 0, 3, 0, 0, 1, 0, 0);   // duplicate right
        vt[6]  = mk(4'b0000, 0, 0, 3, 0, 0, 0, 0, 0);
        vt[7]  = mk(4'b1000, 0, 0, 3, 1, 0, 0, 1, 0);   // single press up
        vt[8]  = mk(4'b1000, 0, 0, 3, 1, 0, 0, 0, 0);
        vt[9]  = mk(4'b0000, 1, 0, 0, 0, 1, 0, 0, 0);
        vt[10] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[11] = mk(4'b0001, 0, 0, 0, 1, 0, 0, 1, 3);   // back to right
        vt[12] = mk(4'b0000, 1, 0, 3, 0, 1, 0, 0, 0);
        vt[13] = mk(4'b0000, 0, 0, 3, 0, 0, 0, 0, 0);
        vt[14] = mk(4'b1000, 0, 0, 3, 1, 0, 0, 1, 0);   // up, left, down
        vt[15] = mk(4'b0000, 0, 0, 3, 1, 0, 0, 0, 0);
        vt[16] = mk(4'b0010, 0, 0, 3, 2, 0, 0, 1, 2);
        vt[17] = mk(4'b0000, 0, 0, 3, 2, 0, 0, 0, 0);
        vt[18] = mk(4'b0100, 0, 0, 3, 2, 0, 1, 0, 0);   // full
        vt[19] = mk(4'b0000, 0, 0, 3, 2, 0, 0, 0, 0);
        vt[20] = mk(4'b0000, 1, 0, 0, 1, 1, 0, 0, 0);
        vt[21] = mk(4'b0000, 1, 0, 2, 0, 1, 0, 0, 0);
        vt[22] = mk(4'b0000, 0, 0, 2, 0, 0, 0, 0, 0);
        vt[23] = mk(4'b1000, 0, 0, 2, 1, 0, 0, 1, 0);
        vt[24] = mk(4'b0000, 1, 1, 2, 1, 0, 0, 0, 0);   // paused tick
        vt[25] = mk(4'b0000, 0, 1, 2, 1, 0, 0, 0, 0);
        vt[26] = mk(4'b0010, 0, 0, 2, 2, 0, 0, 1, 2);
        vt[27] = mk(4'b0000, 0, 0, 2, 2, 0, 0, 0, 0);
        vt[28] = mk(4'b1000, 1, 0, 0, 2, 1, 0, 1, 0);   // full + same-cycle dequeue
        vt[29] = mk(4'b0000, 0, 0, 0, 2, 0, 0, 0, 0);
        vt[30] = mk(4'b0000, 1, 0, 2, 1, 1, 0, 0, 0);
        vt[31] = mk(4'b0000, 1, 0, 0, 0, 1, 0, 0, 0);
        vt[32] = mk(4'b0000, 0, 0, 0, 0, 0, 0, 0, 0);
        vt[33] = mk(4'b0001, 0, 0, 0, 1, 0, 0, 1, 3);
        vt[34] = mk(4'b0000, 1, 0, 3, 0, 1, 0, 0, 0);
        vt[35] = mk(4'b0000, 0, 0, 3, 0, 0, 0, 0, 0);
        vt[36] = mk(4'b1010, 0, 0, 3, 1, 0, 1, 1, 0);   // up+left together
        vt[37] = mk(4'b0000, 0, 0, 3, 1, 0, 0, 0, 0);

        rst_n = 1'b0;
        bus.game_en = 1'b0; bus.pause = 1'b0;
        bus.isUp = 1'b1; bus.isDown = 1'b0; bus.isLeft = 1'b0; bus.isRight = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_heading", int'(bus.heading), 3);
        chk("rst_count",   int'(bus.q_count), 0);
        chk("rst_chg",     int'(bus.heading_chg), 0);
        chk("rst_drop",    int'(bus.drop_evt), 0);
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            {bus.isUp, bus.isDown, bus.isLeft, bus.isRight} = vt[i].btn;
            bus.game_en = vt[i].ge;
            bus.pause   = vt[i].ps;
            if (vt[i].push) exp_q.push_back(vt[i].pd);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_heading", i), int'(bus.heading), int'(vt[i].h));
            chk($sformatf("v%0d_count", i),   int'(bus.q_count), vt[i].cnt);
            chk($sformatf("v%0d_chg", i),     int'(bus.heading_chg), int'(vt[i].chg));
            chk($sformatf("v%0d_drop", i),    int'(bus.drop_evt), int'(vt[i].drop));
        end

        // Async reset mid-queue: outputs clear with no clock edge.
        #2 rst_n = 1'b0;
        #1;
        chk("async_count",   int'(bus.q_count), 0);
        chk("async_heading", int'(bus.heading), 3);
        chk("async_drop",    int'(bus.drop_evt), 0);
        chk("sb_pending",    exp_q.size(), 1);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_count", int'(bus.q_count), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
